sort_sequencer: RTL and testbench

Sequential compare-and-swap controller that buffers a frame of N 16-bit pixel keys, sorts them in ascending unsigned order, and streams them out. It owns exactly one `compare16` instance and sequences it one compare per cycle over the buffer (bubble sort). It sits between the pixel ingest stream and the downstream image sorting output stage.

---
 rtl/sort_sequencer.sv | 160 ++++++++++++++++
 tb/tb_sort_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// sort_sequencer: buffers N unsigned 16-bit keys, bubble-sorts them one compare per cycle, then streams them out.
// Build option SORT_EARLY_EXIT_EN ends SORT after the first pass that performs no swap.

module compare16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        a_bigger,
  output logic        equal,
  output logic        b_bigger
);
  assign a_bigger = (a > b);
  assign equal    = (a == b);
  assign b_bigger = (a < b);
endmodule

module sort_sequencer #(
  parameter int N  = 8,
  parameter int PW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        sort_done,
  output logic [7:0]  swap_count
);
  localparam int            DEPTH     = 1 << PW;
  localparam logic [PW-1:0] LAST_PASS = PW'(N - 2);
  localparam logic [PW-1:0] LAST_WORD = PW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pass;
  logic [PW-1:0] idx;
  logic [PW-1:0] idx_nxt;
  logic [PW-1:0] last_idx;
  logic          a_bigger;
  logic          equal;
  logic          b_bigger;
  logic          final_pass;
  logic          unused_cmp;

  assign idx_nxt  = idx + 1'b1;
  assign last_idx = LAST_PASS - pass;
  assign out_data = mem[rd_ptr];

  compare16 u_cmp (
    .a        (mem[idx]),
    .b        (mem[idx_nxt]),
    .a_bigger (a_bigger),
    .equal    (equal),
    .b_bigger (b_bigger)
  );

  // Only a strict A>B swaps, which keeps equal keys in arrival order.
  assign unused_cmp = equal ^ b_bigger;

`ifdef SORT_EARLY_EXIT_EN
  logic swapped;

  always_ff @(posedge clk) begin
    if (rst || (state != SORT) || (idx == last_idx)) begin
      swapped <= 1'b0;
    end else if (a_bigger) begin
      swapped <= 1'b1;
    end
  end

  assign final_pass = (pass == LAST_PASS) || !(swapped || a_bigger);
`else
  assign final_pass = (pass == LAST_PASS);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sort_done  <= 1'b0;
      swap_count <= 8'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pass       <= '0;
      idx        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 16'd0;
      end
    end else begin
      sort_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mem[0] <= in_data;
            wr_ptr <= PW'(1);
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_WORD) begin
              in_ready   <= 1'b0;
              pass       <= '0;
              idx        <= '0;
              swap_count <= 8'd0;
              state      <= SORT;
            end
          end
        end
        SORT: begin
          if (a_bigger) begin
            mem[idx]     <= mem[idx_nxt];
            mem[idx_nxt] <= mem[idx];
            if (swap_count != 8'hFF) begin
              swap_count <= swap_count + 8'd1;
            end
          end
          if (idx == last_idx) begin
            if (final_pass) begin
              rd_ptr    <= '0;
              sort_done <= 1'b1;
              out_valid <= 1'b1;
              state     <= DRAIN;
            end else begin
              pass <= pass + 1'b1;
              idx  <= '0;
            end
          end else begin
            idx <= idx_nxt;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == LAST_WORD) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_sequencer.sv
// Bench for sort_sequencer (N=8): directed frame table, mid-sort reset, and random frames against a sorting model.
module tb_sort_sequencer;
  localparam int NN = 8;

  typedef logic [NN-1:0][15:0] frame_t;
  typedef struct packed {
    frame_t     din;
    frame_t     dout;
    logic [7:0] swaps;
    logic [7:0] cyc_full;
    logic [7:0] cyc_ee;
    logic [1:0] mode;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        sort_done;
  logic [7:0]  swap_count;

  int checks   = 0;
  int failures = 0;
  int bad_load = 0;

  vec_t vecs [4];

  sort_sequencer #(.N(8), .PW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .sort_done  (sort_done),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, want);
    end
  endtask

  function automatic frame_t mk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    frame_t f;
    f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3;
    f[4] = a4; f[5] = a5; f[6] = a6; f[7] = a7;
    return f;
  endfunction

  function automatic frame_t model_sort(input frame_t d);
    frame_t      s;
    logic [15:0] t;
    s = d;
    for (int i = 1; i < NN; i++)
      for (int j = i; j > 0; j--)
        if (s[j-1] > s[j]) begin
          t = s[j]; s[j] = s[j-1]; s[j-1] = t;
        end
    return s;
  endfunction

  // Adjacent-swap sorting performs exactly one swap per inversion.
  function automatic int model_swaps(input frame_t d);
    int n;
    n = 0;
    for (int j = 0; j < NN; j++)
      for (int i = 0; i < j; i++)
        if (d[i] > d[j]) n++;
    return (n > 255) ? 255 : n;
  endfunction

  // With early exit: passes = largest count of bigger keys ahead of any key, plus one clean pass.
  function automatic int model_cycles(input frame_t d);
    int p;
    int cyc;
`ifdef SORT_EARLY_EXIT_EN
    int k;
    int g;
    k = 0;
    for (int j = 0; j < NN; j++) begin
      g = 0;
      for (int i = 0; i < j; i++)
        if (d[i] > d[j]) g++;
      if (g > k) k = g;
    end
    p = (k + 1 > NN - 1) ? NN - 1 : k + 1;
`else
    p = NN - 1;
`endif
    cyc = 0;
    for (int q = 0; q < p; q++) cyc += NN - 1 - q;
    return cyc;
  endfunction

  task automatic load_frame(input frame_t d);
    for (int i = 0; i < NN; i++) begin
      @(negedge clk);
      if (!in_ready) bad_load++;
      in_valid = 1'b1;
      in_data  = d[i];
    end
  endtask

  task automatic run_frame(input frame_t din, input frame_t want, input int want_swaps,
                           input int want_cyc, input int mode, input string tag);
    int          sort_cyc;
    int          pulses;
    int          bad_ir;
    int          bad_busy;
    int          bad_hold;
    int          bad_ov;
    int          n;
    int          cyc;
    bit          got_done;
    bit          prev_stall;
    bit          rdy;
    logic [15:0] prev_dat;
    logic [15:0] got [NN];

    bad_load = 0;
    load_frame(din);
    chk({tag, "_load_ready"}, bad_load, 0);

    sort_cyc = 0; pulses = 0; bad_ir = 0; bad_busy = 0; got_done = 0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge clk);
      if (sort_done) begin
        got_done = 1;
        pulses++;
      end else begin
        sort_cyc++;
        if (in_ready) bad_ir++;
        if (!busy) bad_busy++;
        in_valid = 1'b1;
        in_data  = 16'($urandom);
      end
    end
    chk({tag, "_sort_done_seen"}, int'(got_done), 1);
    chk({tag, "_sort_cycles"}, sort_cyc, want_cyc);
    chk({tag, "_swap_count"}, int'(swap_count), want_swaps);
    chk({tag, "_out_valid_with_done"}, int'(out_valid), 1);

    n = 0; cyc = 0; prev_stall = 0; prev_dat = '0; bad_hold = 0; bad_ov = 0;
    for (int i = 0; i < NN; i++) got[i] = 16'hDEAD;
    while (n < NN && cyc < 200) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (sort_done) pulses++;
      end
      if (in_ready) bad_ir++;
      if (!busy) bad_busy++;
      if (!out_valid) bad_ov++;
      if (prev_stall && (out_data !== prev_dat)) bad_hold++;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      out_ready = rdy;
      in_valid  = 1'b1;
      in_data   = 16'($urandom);
      if (out_valid && rdy) begin
        got[n] = out_data;
        n++;
        if (n == NN) in_valid = 1'b0;
      end
      prev_stall = out_valid && !rdy;
      prev_dat   = out_data;
      cyc++;
    end
    chk({tag, "_drain_words"}, n, NN);
    chk({tag, "_in_ready_low"}, bad_ir, 0);
    chk({tag, "_busy_high"}, bad_busy, 0);
    chk({tag, "_out_valid_high"}, bad_ov, 0);
    chk({tag, "_stall_hold"}, bad_hold, 0);
    for (int i = 0; i < NN; i++)
      chk($sformatf("%s_out%0d", tag, i), int'(got[i]), int'(want[i]));

    @(negedge clk);
    out_ready = 1'b0;
    if (sort_done) pulses++;
    chk({tag, "_sort_done_pulses"}, pulses, 1);
    chk({tag, "_idle_in_ready"}, int'(in_ready), 1);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_out_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    vecs[0] = '{din: mk(8, 7, 6, 5, 4, 3, 2, 1), dout: mk(1, 2, 3, 4, 5, 6, 7, 8),
                swaps: 8'd28, cyc_full: 8'd28, cyc_ee: 8'd28, mode: 2'd0};
    vecs[1] = '{din:  mk(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h8001, 16'h0000),
                dout: mk(16'h0000, 16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF),
                swaps: 8'd16, cyc_full: 8'd28, cyc_ee: 8'd28, mode: 2'd1};
    vecs[2] = '{din: mk(1, 2, 3, 4, 5, 6, 7, 8), dout: mk(1, 2, 3, 4, 5, 6, 7, 8),
                swaps: 8'd0, cyc_full: 8'd28, cyc_ee: 8'd7, mode: 2'd1};
    vecs[3] = '{din: mk(5, 5, 3, 3, 9, 0, 1, 2), dout: mk(0, 1, 2, 3, 3, 5, 5, 9),
                swaps: 8'd19, cyc_full: 8'd28, cyc_ee: 8'd27, mode: 2'd2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sort_done", int'(sort_done), 0);
    chk("rst_swap_count", int'(swap_count), 0);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
`ifdef SORT_EARLY_EXIT_EN
      run_frame(vecs[v].din, vecs[v].dout, int'(vecs[v].swaps), int'(vecs[v].cyc_ee),
                int'(vecs[v].mode), $sformatf("vec%0d", v));
`else
      run_frame(vecs[v].din, vecs[v].dout, int'(vecs[v].swaps), int'(vecs[v].cyc_full),
                int'(vecs[v].mode), $sformatf("vec%0d", v));
`endif
    end

    // Reset in SORT cycle 10 of a reversed frame: 9 compares done, all of them swaps.
    bad_load = 0;
    load_frame(vecs[0].din);
    for (int c = 0; c < 10; c++) @(negedge clk);
    chk("midsort_busy", int'(busy), 1);
    chk("midsort_swaps", int'(swap_count), 9);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midsort_rst_in_ready", int'(in_ready), 1);
    chk("midsort_rst_busy", int'(busy), 0);
    chk("midsort_rst_swaps", int'(swap_count), 0);
    chk("midsort_rst_out_valid", int'(out_valid), 0);
    chk("midsort_rst_out_data", int'(out_data), 0);

`ifdef SORT_EARLY_EXIT_EN
    run_frame(vecs[3].din, vecs[3].dout, int'(vecs[3].swaps), int'(vecs[3].cyc_ee), int'(vecs[3].mode), "vec3");
`else
    run_frame(vecs[3].din, vecs[3].dout, int'(vecs[3].swaps), int'(vecs[3].cyc_full), int'(vecs[3].mode), "vec3");
`endif

    for (int r = 0; r < 12; r++) begin
      frame_t f;
      for (int i = 0; i < NN; i++)
        f[i] = (r % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      run_frame(f, model_sort(f), model_swaps(f), model_cycles(f),
                int'($urandom_range(0, 2)), $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
